// File: rtl/ifu_fetch.sv
// Instruction-fetch requester: issues one-beat PC-addressed reads, captures the
// returned word and presents {pc, inst} downstream; handles redirects and timeouts.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err,
    output logic [1:0]  dbg_state
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]    r_state;
    logic [31:0]   r_pc;
    logic          r_kill;
    logic [CW-1:0] r_wait_cnt;
    logic          r_mem_req;
    logic [31:0]   r_mem_addr;
    logic          r_out_valid;
    logic [31:0]   r_out_pc;
    logic [31:0]   r_out_inst;
    logic          r_fetch_err;

    logic [31:0]   w_redir_pc;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_timeout;

    assign w_redir_pc = {redirect_pc[31:2], 2'b00};
    assign w_cnt_nxt  = r_wait_cnt + 1'b1;
    // Timeout fires on the TIMEOUT-th WAIT cycle (the count includes the current cycle).
    assign w_timeout  = (w_cnt_nxt == CW'(TIMEOUT));

    // Downstream handshake: a beat transfers on any cycle with out_valid & out_ready
    // and no redirect; while out_valid is high and unaccepted, out_pc/out_inst hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_kill      <= 1'b0;
            r_wait_cnt  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= RESET_PC;
            r_out_valid <= 1'b0;
            r_out_pc    <= '0;
            r_out_inst  <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            r_mem_req <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_state   <= S_REQ;
                    r_mem_req <= 1'b1;
                    if (redirect_valid) begin
                        r_pc       <= w_redir_pc;
                        r_mem_addr <= w_redir_pc;
                    end else begin
                        r_mem_addr <= r_pc;
                    end
                end
                S_REQ: begin
                    r_state    <= S_WAIT;
                    r_wait_cnt <= '0;
                    // The request already on the bus must still be drained.
                    if (redirect_valid) begin
                        r_pc   <= w_redir_pc;
                        r_kill <= 1'b1;
                    end
                end
                S_WAIT: begin
                    r_wait_cnt <= w_cnt_nxt;
                    if (redirect_valid) begin
                        r_pc <= w_redir_pc;
                        if (mem_ready || w_timeout) begin
                            r_kill     <= 1'b0;
                            r_state    <= S_REQ;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= w_redir_pc;
                        end else begin
                            r_kill <= 1'b1;
                        end
                    end else if (mem_ready) begin
                        if (r_kill) begin
                            r_kill     <= 1'b0;
                            r_state    <= S_REQ;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= r_pc;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_out_pc    <= r_pc;
                            r_out_inst  <= mem_data;
                            r_state     <= S_HOLD;
                        end
                    end else if (w_timeout) begin
                        r_fetch_err <= 1'b1;
                        r_kill      <= 1'b0;
                        r_state     <= S_REQ;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= r_pc;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        r_out_valid <= 1'b0;
                        r_pc        <= w_redir_pc;
                        r_state     <= S_REQ;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= w_redir_pc;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_pc        <= r_pc + 32'd4;
                        r_state     <= S_REQ;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= r_pc + 32'd4;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign out_valid = r_out_valid;
    assign out_pc    = r_out_pc;
    assign out_inst  = r_out_inst;
    assign fetch_err = r_fetch_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: SRAM responder, request/transfer monitor
// and expected queues for request addresses and downstream beats.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [1:0]  S_WAIT   = 2'd2;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_err;
    logic [1:0]  dbg_state;

    ifu_fetch #(.RESET_PC(RESET_PC), .TIMEOUT(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ready      (mem_ready),
        .mem_data       (mem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_err      (fetch_err),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          xfer_cnt = 0;
    int          xfer_cyc[$];
    logic [31:0] addr_q[$];
    logic [63:0] exp_q[$];

    int          resp_lat = 1;
    int          drop_n = 0;
    logic        manual = 1'b0;
    logic        stray_ok = 1'b1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_req(input string tag, input int budget);
        for (int i = 0; i < budget && !mem_req; i++) tick();
        check(tag, mem_req, 1'b1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget && !out_valid; i++) tick();
        check(tag, out_valid, 1'b1);
    endtask

    task automatic wait_xfer(input string tag, input int budget);
        int start;
        start = xfer_cnt;
        for (int i = 0; i < budget && xfer_cnt == start; i++) tick();
        check(tag, (xfer_cnt > start), 1'b1);
    endtask

    task automatic push_beat(input logic [31:0] pc);
        exp_q.push_back({pc, pc ^ 32'hFFFF_FFFF});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stray_ok = 1'b1;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        manual = 1'b0;
        drop_n = 0;
        resp_lat = 1;
        mem_ready = 1'b0;
        tick();
        tick();
        addr_q.delete();
        exp_q.delete();
        xfer_cyc.delete();
        stray_ok = 1'b0;
        rst = 1'b0;
    endtask

    task automatic end_test(input string tag);
        for (int i = 0; i < 8; i++) tick();
        check({tag, "_addr_q_empty"}, addr_q.size(), 0);
        check({tag, "_exp_q_empty"}, exp_q.size(), 0);
    endtask

    // Redirect while a fetch of RESET_PC is outstanding; `off` cycles after the REQ cycle.
    task automatic redir_case(input string tag, input int lat, input int off, input logic [31:0] tgt);
        logic [31:0] t;
        t = {tgt[31:2], 2'b00};
        do_reset();
        resp_lat = lat;
        addr_q.push_back(RESET_PC);
        addr_q.push_back(t);
        addr_q.push_back(t + 32'd4);
        push_beat(t);
        wait_req({tag, "_req"}, 20);
        for (int i = 0; i < off; i++) tick();
        redirect_valid = 1'b1;
        redirect_pc = tgt;
        tick();
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        wait_xfer({tag, "_xfer"}, 40);
        out_ready = 1'b0;
        end_test(tag);
    endtask

    // SRAM responder: data = addr ^ FFFF_FFFF after resp_lat cycles
    initial begin
        int          pend;
        logic [31:0] lat_addr;
        pend = 0;
        lat_addr = '0;
        forever begin
            @(posedge clk);
            #1;
            if (manual) begin
                pend = 0;
            end else begin
                mem_ready = 1'b0;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        mem_ready = 1'b1;
                        mem_data = lat_addr ^ 32'hFFFF_FFFF;
                    end
                end
                if (mem_req === 1'b1 && !rst) begin
                    if (drop_n > 0) drop_n--;
                    else begin
                        pend = resp_lat;
                        lat_addr = mem_addr;
                    end
                end
            end
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (mem_req) begin
                if (addr_q.size() == 0) check("req_unexpected", mem_req, 1'b0);
                else check("mem_addr", mem_addr, addr_q.pop_front());
            end
            if (out_valid && out_ready && !redirect_valid) begin
                xfer_cnt++;
                xfer_cyc.push_back(cyc);
                if (exp_q.size() == 0) check("xfer_unexpected", out_valid & out_ready, 1'b0);
                else check("beat", {out_pc, out_inst}, exp_q.pop_front());
            end
            if (mem_ready && !stray_ok) check("ready_in_wait", dbg_state, S_WAIT);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int          saved;
        rst = 1'b1;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        mem_ready = 1'b0;
        mem_data = '0;
        tick();
        tick();
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, RESET_PC);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_fetch_err", fetch_err, 1'b0);
        check("rst_state", dbg_state, 2'd0);

        // 1: streaming fetch, one beat every 3 cycles
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) addr_q.push_back(RESET_PC + 32'(4 * i));
        exp_q.push_back({32'h8000_0000, 32'h7FFF_FFFF});
        exp_q.push_back({32'h8000_0004, 32'h7FFF_FFFB});
        exp_q.push_back({32'h8000_0008, 32'h7FFF_FFF7});
        for (int i = 0; i < 3; i++) wait_xfer("t1_xfer", 20);
        out_ready = 1'b0;
        if (xfer_cyc.size() == 3) begin
            check("t1_gap0", xfer_cyc[1] - xfer_cyc[0], 3);
            check("t1_gap1", xfer_cyc[2] - xfer_cyc[1], 3);
        end else begin
            check("t1_xfer_count", xfer_cyc.size(), 3);
        end
        end_test("t1");

        // 2: downstream stall holds the payload, no new request
        do_reset();
        addr_q.push_back(RESET_PC);
        wait_valid("t2_valid", 20);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_pc", out_pc, 32'h8000_0000);
            check("t2_hold_inst", out_inst, 32'h7FFF_FFFF);
            check("t2_hold_valid", out_valid, 1'b1);
            check("t2_no_req", mem_req, 1'b0);
            tick();
        end
        push_beat(RESET_PC);
        addr_q.push_back(RESET_PC + 32'd4);
        out_ready = 1'b1;
        wait_xfer("t2_xfer", 5);
        out_ready = 1'b0;
        end_test("t2");

        // 3: redirects in WAIT (slow responder), in REQ, and in WAIT coincident with mem_ready
        redir_case("t3_wait", 3, 1, 32'h8000_0103);
        redir_case("t3_req", 1, 0, 32'h8000_0042);
        redir_case("t3_same", 1, 1, 32'h8000_0FFE);

        // 4: redirect and out_ready together in HOLD
        do_reset();
        addr_q.push_back(RESET_PC);
        addr_q.push_back(32'h8000_0200);
        wait_valid("t4_valid", 20);
        saved = xfer_cnt;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0201;
        out_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        check("t4_no_xfer", xfer_cnt, saved);
        check("t4_valid_low", out_valid, 1'b0);
        check("t4_req", mem_req, 1'b1);
        check("t4_addr", mem_addr, 32'h8000_0200);
        end_test("t4");

        // 5: silent responder -> timeout, reissue, recover with sticky error
        do_reset();
        drop_n = 1;
        addr_q.push_back(RESET_PC);
        addr_q.push_back(RESET_PC);
        addr_q.push_back(RESET_PC + 32'd4);
        push_beat(RESET_PC);
        wait_req("t5_req", 20);
        for (int i = 0; i < 16; i++) begin
            tick();
            check("t5_err_low", fetch_err, 1'b0);
            check("t5_no_req", mem_req, 1'b0);
        end
        tick();
        check("t5_err_high", fetch_err, 1'b1);
        check("t5_reissue", mem_req, 1'b1);
        check("t5_reissue_addr", mem_addr, RESET_PC);
        out_ready = 1'b1;
        wait_xfer("t5_xfer", 20);
        out_ready = 1'b0;
        check("t5_err_sticky", fetch_err, 1'b1);
        end_test("t5");

        // 6: async reset in WAIT, then a stray mem_ready one cycle after release
        do_reset();
        resp_lat = 3;
        out_ready = 1'b1;
        addr_q.push_back(RESET_PC);
        wait_req("t6_req", 20);
        tick();
        #1;
        manual = 1'b1;
        mem_ready = 1'b0;
        stray_ok = 1'b1;
        rst = 1'b1;
        #1;
        check("t6_async_req", mem_req, 1'b0);
        check("t6_async_addr", mem_addr, RESET_PC);
        check("t6_async_valid", out_valid, 1'b0);
        check("t6_async_err", fetch_err, 1'b0);
        check("t6_async_state", dbg_state, 2'd0);
        tick();
        tick();
        rst = 1'b0;
        addr_q.push_back(RESET_PC);
        addr_q.push_back(RESET_PC + 32'd4);
        push_beat(RESET_PC);
        tick();
        mem_ready = 1'b1;
        mem_data = 32'hDEAD_BEEF;
        tick();
        mem_ready = 1'b0;
        stray_ok = 1'b0;
        tick();
        mem_ready = 1'b1;
        mem_data = 32'h7FFF_FFFF;
        tick();
        mem_ready = 1'b0;
        manual = 1'b0;
        wait_xfer("t6_xfer", 10);
        out_ready = 1'b0;
        end_test("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
